// File: rtl/intersect_arbiter.sv
// Shares one intersect_unit between two requesters, granting a whole fiber-tree
// stream (first flit through done token) at a time in round-robin order.
module intersect_arbiter #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] DONE_VAL   = 16'h0100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      tile_en,

    input  logic [2*DATA_WIDTH+1:0]   r0_op0,
    input  logic                      r0_op0_valid,
    output logic                      r0_op0_ready,
    input  logic [2*DATA_WIDTH+1:0]   r0_op1,
    input  logic                      r0_op1_valid,
    output logic                      r0_op1_ready,
    input  logic [2*DATA_WIDTH+1:0]   r1_op0,
    input  logic                      r1_op0_valid,
    output logic                      r1_op0_ready,
    input  logic [2*DATA_WIDTH+1:0]   r1_op1,
    input  logic                      r1_op1_valid,
    output logic                      r1_op1_ready,

    output logic [3*DATA_WIDTH+2:0]   r0_res,
    output logic                      r0_res_valid,
    input  logic                      r0_res_ready,
    output logic [3*DATA_WIDTH+2:0]   r1_res,
    output logic                      r1_res_valid,
    input  logic                      r1_res_ready,

    output logic [DATA_WIDTH:0]       coord_in_0,
    output logic                      coord_in_0_valid,
    input  logic                      coord_in_0_ready,
    output logic [DATA_WIDTH:0]       pos_in_0,
    output logic                      pos_in_0_valid,
    input  logic                      pos_in_0_ready,
    output logic [DATA_WIDTH:0]       coord_in_1,
    output logic                      coord_in_1_valid,
    input  logic                      coord_in_1_ready,
    output logic [DATA_WIDTH:0]       pos_in_1,
    output logic                      pos_in_1_valid,
    input  logic                      pos_in_1_ready,

    input  logic [DATA_WIDTH:0]       coord_out,
    input  logic                      coord_out_valid,
    output logic                      coord_out_ready,
    input  logic [DATA_WIDTH:0]       pos_out_0,
    input  logic                      pos_out_0_valid,
    output logic                      pos_out_0_ready,
    input  logic [DATA_WIDTH:0]       pos_out_1,
    input  logic                      pos_out_1_valid,
    output logic                      pos_out_1_ready,

    output logic                      owner,
    output logic                      busy
);

    localparam int F = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_rr_ptr;
    logic       r_busy;
    logic [1:0] r_c_sent;
    logic [1:0] r_p_sent;
    logic [1:0] r_op_done;
    logic       r_res_done;

    logic [1:0][2*F-1:0] w_op;
    logic [1:0]          w_op_valid;
    logic [1:0]          w_c_ready;
    logic [1:0]          w_p_ready;
    logic [1:0]          w_c_valid;
    logic [1:0]          w_p_valid;
    logic [1:0]          w_op_ready;
    logic [1:0]          w_acc;
    logic [1:0]          w_is_done;
    logic [1:0]          w_op_done_n;
    logic                w_feed;
    logic                w_join;
    logic                w_res_valid;
    logic                w_res_ready;
    logic                w_res_xfer;
    logic                w_res_done_n;
    logic                w_cand0;
    logic                w_cand1;
    logic                w_grant;

    function automatic logic is_done_tok(input logic [F-1:0] flit);
        return flit[F-1] & (flit[F-2:0] == DONE_VAL);
    endfunction

    assign w_feed = clk_en & (r_state == ST_FEED);
    assign w_join = clk_en & ((r_state == ST_FEED) | (r_state == ST_DRAIN));

    assign w_c_ready = {coord_in_1_ready, coord_in_0_ready};
    assign w_p_ready = {pos_in_1_ready, pos_in_0_ready};

    // Select the owner's operand streams onto the internal datapath.
    always_comb begin
        w_op       = '0;
        w_op_valid = 2'b00;
        if (r_owner) begin
            w_op[0]    = r1_op0;
            w_op[1]    = r1_op1;
            w_op_valid = {r1_op1_valid, r1_op0_valid};
        end else begin
            w_op[0]    = r0_op0;
            w_op[1]    = r0_op1;
            w_op_valid = {r0_op1_valid, r0_op0_valid};
        end
    end

    // Fork each operand flit into coord/pos halves; a half already delivered is held back
    // until its partner goes, so skewed readies never duplicate or drop a half.
    always_comb begin
        w_c_valid   = 2'b00;
        w_p_valid   = 2'b00;
        w_op_ready  = 2'b00;
        w_acc       = 2'b00;
        w_is_done   = 2'b00;
        w_op_done_n = 2'b00;
        for (int k = 0; k < 2; k++) begin
            w_c_valid[k]   = w_feed & ~r_op_done[k] & w_op_valid[k] & ~r_c_sent[k];
            w_p_valid[k]   = w_feed & ~r_op_done[k] & w_op_valid[k] & ~r_p_sent[k];
            w_op_ready[k]  = w_feed & ~r_op_done[k]
                           & (r_c_sent[k] | w_c_ready[k]) & (r_p_sent[k] | w_p_ready[k]);
            w_acc[k]       = w_op_ready[k] & w_op_valid[k];
            w_is_done[k]   = is_done_tok(w_op[k][F-1:0]);
            w_op_done_n[k] = r_op_done[k] | (w_acc[k] & w_is_done[k]);
        end
    end

    assign coord_in_0       = w_op[0][F-1:0];
    assign pos_in_0         = w_op[0][2*F-1:F];
    assign coord_in_1       = w_op[1][F-1:0];
    assign pos_in_1         = w_op[1][2*F-1:F];
    assign coord_in_0_valid = w_c_valid[0];
    assign pos_in_0_valid   = w_p_valid[0];
    assign coord_in_1_valid = w_c_valid[1];
    assign pos_in_1_valid   = w_p_valid[1];

    assign r0_op0_ready = w_op_ready[0] & ~r_owner;
    assign r0_op1_ready = w_op_ready[1] & ~r_owner;
    assign r1_op0_ready = w_op_ready[0] &  r_owner;
    assign r1_op1_ready = w_op_ready[1] &  r_owner;

    // The three unit outputs move as one result flit, only toward the owner.
    assign w_res_valid  = w_join & ~r_res_done & coord_out_valid & pos_out_0_valid & pos_out_1_valid;
    assign w_res_ready  = r_owner ? r1_res_ready : r0_res_ready;
    assign w_res_xfer   = w_res_valid & w_res_ready;
    assign w_res_done_n = r_res_done | (w_res_xfer & is_done_tok(coord_out));

    assign coord_out_ready = w_res_xfer;
    assign pos_out_0_ready = w_res_xfer;
    assign pos_out_1_ready = w_res_xfer;

    assign r0_res       = {pos_out_1, pos_out_0, coord_out};
    assign r1_res       = {pos_out_1, pos_out_0, coord_out};
    assign r0_res_valid = w_res_valid & ~r_owner;
    assign r1_res_valid = w_res_valid &  r_owner;

    assign w_cand0 = tile_en & (r0_op0_valid | r0_op1_valid);
    assign w_cand1 = tile_en & (r1_op0_valid | r1_op1_valid);
    assign w_grant = (w_cand0 & w_cand1) ? r_rr_ptr : w_cand1;

    // Grant state machine plus per-operand sent/done bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_busy     <= 1'b0;
            r_c_sent   <= 2'b00;
            r_p_sent   <= 2'b00;
            r_op_done  <= 2'b00;
            r_res_done <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cand0 | w_cand1) begin
                        r_owner <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= ST_FEED;
                    end
                end
                ST_FEED, ST_DRAIN: begin
                    for (int k = 0; k < 2; k++) begin
                        if (w_acc[k]) begin
                            r_c_sent[k] <= 1'b0;
                            r_p_sent[k] <= 1'b0;
                        end else begin
                            if (w_c_valid[k] & w_c_ready[k]) r_c_sent[k] <= 1'b1;
                            if (w_p_valid[k] & w_p_ready[k]) r_p_sent[k] <= 1'b1;
                        end
                    end
                    r_op_done  <= w_op_done_n;
                    r_res_done <= w_res_done_n;
                    // Leave on the edge that completes the last done token so busy drops next cycle.
                    if ((w_op_done_n == 2'b11) && w_res_done_n) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_rr_ptr   <= ~r_owner;
                        r_c_sent   <= 2'b00;
                        r_p_sent   <= 2'b00;
                        r_op_done  <= 2'b00;
                        r_res_done <= 1'b0;
                    end else if (w_op_done_n == 2'b11) begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
